// File: rtl/wbp2classic.sv
// Bridge from a pipelined Wishbone master port to a classic Wishbone slave port.
// Accepted requests are queued and replayed in order as single classic STB/ACK cycles.
module wbp2classic #(
  parameter int AW      = 30,
  parameter int DW      = 32,
  parameter int LGDEPTH = 2
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_mcyc,
  input  logic            i_mstb,
  input  logic            i_mwe,
  input  logic [AW-1:0]   i_maddr,
  input  logic [DW-1:0]   i_mdata,
  input  logic [DW/8-1:0] i_msel,
  output logic            o_mstall,
  output logic            o_mack,
  output logic [DW-1:0]   o_mdata,
  output logic            o_merr,
  output logic            o_scyc,
  output logic            o_sstb,
  output logic            o_swe,
  output logic [AW-1:0]   o_saddr,
  output logic [DW-1:0]   o_sdata,
  output logic [DW/8-1:0] o_ssel,
  input  logic            i_sack,
  input  logic [DW-1:0]   i_sdata,
  input  logic            i_serr
);

  localparam int SW    = DW / 8;
  localparam int EW    = 1 + AW + DW + SW;
  localparam int DEPTH = 1 << LGDEPTH;
  localparam logic [LGDEPTH:0] FULL_COUNT = (LGDEPTH + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, BUSY, ERRDRAIN} state_t;

  state_t state, state_n;

  logic [EW-1:0]      fifo_mem [DEPTH];
  logic [LGDEPTH-1:0] wr_ptr, rd_ptr;
  logic [LGDEPTH:0]   count;

  logic          push, pop, flush;
  logic          fifo_empty, fifo_full, avail;
  logic [EW-1:0] push_entry, head;

  logic          cyc_q, cyc_n;
  logic [EW-1:0] req_q, req_n;
  logic          mack_n, merr_n;
  logic [DW-1:0] mdata_n;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == FULL_COUNT);
  assign o_mstall   = i_reset | fifo_full | (state == ERRDRAIN);
  assign push       = i_mcyc & i_mstb & ~o_mstall;
  assign push_entry = {i_mwe, i_maddr, i_mdata, i_msel};

  // An empty FIFO forwards a same-cycle request straight to the classic side
  assign head  = fifo_empty ? push_entry : fifo_mem[rd_ptr];
  assign avail = ~fifo_empty | push;

  assign o_scyc = cyc_q;
  assign o_sstb = cyc_q;
  assign {o_swe, o_saddr, o_sdata, o_ssel} = req_q;

  always_comb begin
    state_n = state;
    cyc_n   = cyc_q;
    req_n   = req_q;
    mack_n  = 1'b0;
    merr_n  = 1'b0;
    mdata_n = o_mdata;
    pop     = 1'b0;
    flush   = 1'b0;
    if (!i_mcyc) begin
      // Master abort discards the queue and any response arriving this cycle
      state_n = IDLE;
      cyc_n   = 1'b0;
      flush   = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (avail) begin
            pop     = 1'b1;
            req_n   = head;
            cyc_n   = 1'b1;
            state_n = BUSY;
          end
        end
        BUSY: begin
          if (i_serr) begin
            merr_n  = 1'b1;
            flush   = 1'b1;
            cyc_n   = 1'b0;
            state_n = ERRDRAIN;
          end else if (i_sack) begin
            mack_n  = 1'b1;
            mdata_n = i_sdata;
            if (avail) begin
              pop   = 1'b1;
              req_n = head;
            end else begin
              cyc_n   = 1'b0;
              state_n = IDLE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state   <= IDLE;
      cyc_q   <= 1'b0;
      req_q   <= '0;
      o_mack  <= 1'b0;
      o_merr  <= 1'b0;
      o_mdata <= '0;
    end else begin
      state   <= state_n;
      cyc_q   <= cyc_n;
      req_q   <= req_n;
      o_mack  <= mack_n;
      o_merr  <= merr_n;
      o_mdata <= mdata_n;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + LGDEPTH'(1);
      if (pop)
        rd_ptr <= rd_ptr + LGDEPTH'(1);
      case ({push, pop})
        2'b10:   count <= count + (LGDEPTH + 1)'(1);
        2'b01:   count <= count - (LGDEPTH + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; occupancy alone decides what is valid
  always_ff @(posedge i_clk) begin
    if (push)
      fifo_mem[wr_ptr] <= push_entry;
  end

endmodule

// File: tb/tb_wbp2classic.sv
// Directed self-checking bench for wbp2classic: single read, burst fill,
// zero-wait slave, error mid-burst, master abort and reset mid-cycle.
module tb_wbp2classic;

  localparam int AW = 30;
  localparam int DW = 32;

  logic            i_clk = 1'b0;
  logic            i_reset;
  logic            i_mcyc, i_mstb, i_mwe;
  logic [AW-1:0]   i_maddr;
  logic [DW-1:0]   i_mdata;
  logic [DW/8-1:0] i_msel;
  logic            o_mstall, o_mack, o_merr;
  logic [DW-1:0]   o_mdata;
  logic            o_scyc, o_sstb, o_swe;
  logic [AW-1:0]   o_saddr;
  logic [DW-1:0]   o_sdata;
  logic [DW/8-1:0] o_ssel;
  logic            i_sack, i_serr;
  logic [DW-1:0]   i_sdata;

  logic            tie_ack;
  logic            sack_drv;
  logic [DW-1:0]   sdata_drv;

  int errors = 0;
  int checks = 0;
  int m, acks, exp_addr;
  logic stb_now, sack_now, exp_stall, exp_busy, exp_mack;

  always #5 i_clk = ~i_clk;

  // Zero-wait slave mode acks whatever is strobed, returning address-derived data
  assign i_sack  = tie_ack ? o_sstb : sack_drv;
  assign i_sdata = tie_ack ? ({2'b00, o_saddr} ^ 32'h5A5A0000) : sdata_drv;

  wbp2classic #(.AW(AW), .DW(DW), .LGDEPTH(2)) dut (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_mcyc   (i_mcyc),
    .i_mstb   (i_mstb),
    .i_mwe    (i_mwe),
    .i_maddr  (i_maddr),
    .i_mdata  (i_mdata),
    .i_msel   (i_msel),
    .o_mstall (o_mstall),
    .o_mack   (o_mack),
    .o_mdata  (o_mdata),
    .o_merr   (o_merr),
    .o_scyc   (o_scyc),
    .o_sstb   (o_sstb),
    .o_swe    (o_swe),
    .o_saddr  (o_saddr),
    .o_sdata  (o_sdata),
    .o_ssel   (o_ssel),
    .i_sack   (i_sack),
    .i_sdata  (i_sdata),
    .i_serr   (i_serr)
  );

  task automatic check_bit(input string tag, input logic observed, input logic expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  task automatic check_word(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Starts a new cycle: inputs change 1 time unit after the edge, checks follow once settled
  task automatic apply_stimulus(input logic mcyc, input logic mstb, input logic mwe,
                                input logic [AW-1:0] addr, input logic [DW-1:0] data,
                                input logic sack, input logic serr, input logic [DW-1:0] sdata);
    @(posedge i_clk);
    #1;
    i_mcyc    = mcyc;
    i_mstb    = mstb;
    i_mwe     = mwe;
    i_maddr   = addr;
    i_mdata   = data;
    sack_drv  = sack;
    i_serr    = serr;
    sdata_drv = sdata;
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    i_reset   = 1'b1;
    tie_ack   = 1'b0;
    i_msel    = '0;
    i_mcyc    = 1'b0;
    i_mstb    = 1'b0;
    i_mwe     = 1'b0;
    i_maddr   = '0;
    i_mdata   = '0;
    sack_drv  = 1'b0;
    i_serr    = 1'b0;
    sdata_drv = '0;

    // Reset state
    apply_stimulus(0, 0, 0, 30'h0, 32'h0, 0, 0, 32'h0);
    apply_stimulus(0, 0, 0, 30'h0, 32'h0, 0, 0, 32'h0);
    check_bit("rst_stall", o_mstall, 1'b1);
    check_bit("rst_scyc", o_scyc, 1'b0);
    check_bit("rst_sstb", o_sstb, 1'b0);
    check_bit("rst_mack", o_mack, 1'b0);
    check_bit("rst_merr", o_merr, 1'b0);
    check_word("rst_mdata", 64'(o_mdata), 64'h0);
    check_word("rst_saddr", 64'(o_saddr), 64'h0);
    i_reset = 1'b0;
    #1;
    check_bit("rst_release_stall", o_mstall, 1'b0);

    // Single read: accept at c0, ack at c3
    $display("[TB] single read");
    i_msel = 4'h3;
    apply_stimulus(1, 1, 0, 30'h10, 32'h0, 0, 0, 32'h0);
    check_bit("sr_c0_stall", o_mstall, 1'b0);
    check_bit("sr_c0_sstb", o_sstb, 1'b0);
    apply_stimulus(1, 0, 0, 30'h0, 32'h0, 0, 0, 32'h0);
    check_bit("sr_c1_sstb", o_sstb, 1'b1);
    check_word("sr_c1_saddr", 64'(o_saddr), 64'h10);
    check_bit("sr_c1_swe", o_swe, 1'b0);
    check_word("sr_c1_ssel", 64'(o_ssel), 64'h3);
    check_bit("sr_c1_mack", o_mack, 1'b0);
    apply_stimulus(1, 0, 0, 30'h0, 32'h0, 0, 0, 32'h0);
    check_bit("sr_c2_sstb", o_sstb, 1'b1);
    apply_stimulus(1, 0, 0, 30'h0, 32'h0, 1, 0, 32'hDEADBEEF);
    check_bit("sr_c3_sstb", o_sstb, 1'b1);
    check_word("sr_c3_saddr", 64'(o_saddr), 64'h10);
    apply_stimulus(1, 0, 0, 30'h0, 32'h0, 0, 0, 32'h0);
    check_bit("sr_c4_mack", o_mack, 1'b1);
    check_word("sr_c4_mdata", 64'(o_mdata), 64'hDEADBEEF);
    check_bit("sr_c4_scyc", o_scyc, 1'b0);
    apply_stimulus(1, 0, 0, 30'h0, 32'h0, 0, 0, 32'h0);
    check_bit("sr_c5_mack", o_mack, 1'b0);
    check_word("sr_c5_mdata_hold", 64'(o_mdata), 64'hDEADBEEF);

    // Burst fill: first cycle slow, then one wait state each
    $display("[TB] burst fill");
    i_msel = 4'hF;
    m = 0;
    acks = 0;
    for (int c = 0; c <= 17; c++) begin
      stb_now   = (m < 6);
      sack_now  = (c == 5) || (c == 7) || (c == 9) || (c == 11) || (c == 13) || (c == 15);
      exp_stall = (c == 5) || (c == 7);
      exp_busy  = (c >= 1) && (c <= 15);
      exp_addr  = (c <= 5) ? 0 : ((c - 6) / 2 + 1);
      exp_mack  = (c >= 6) && (c <= 16) && ((c % 2) == 0);
      apply_stimulus(1, stb_now, 1, AW'(m), DW'(32'hA0 + m), sack_now, 0, 32'h0);
      check_bit($sformatf("bf_c%0d_stall", c), o_mstall, exp_stall);
      check_bit($sformatf("bf_c%0d_scyc", c), o_scyc, exp_busy);
      if (exp_busy) begin
        check_word($sformatf("bf_c%0d_saddr", c), 64'(o_saddr), 64'(exp_addr));
        check_word($sformatf("bf_c%0d_sdata", c), 64'(o_sdata), 64'(32'hA0 + exp_addr));
        check_bit($sformatf("bf_c%0d_swe", c), o_swe, 1'b1);
      end
      check_bit($sformatf("bf_c%0d_mack", c), o_mack, exp_mack);
      if (o_mack)
        acks++;
      if (stb_now && !exp_stall)
        m++;
    end
    check_word("bf_ack_count", 64'(acks), 64'd6);

    // Zero-wait slave: back-to-back classic cycles and acks
    $display("[TB] zero-wait slave");
    tie_ack = 1'b1;
    for (int c = 0; c <= 5; c++) begin
      exp_busy = (c >= 1) && (c <= 4);
      exp_mack = (c >= 2) && (c <= 5);
      apply_stimulus(1, (c < 4), 0, AW'(32'h20 + c), 32'h0, 0, 0, 32'h0);
      check_bit($sformatf("zw_c%0d_stall", c), o_mstall, 1'b0);
      check_bit($sformatf("zw_c%0d_scyc", c), o_scyc, exp_busy);
      if (exp_busy)
        check_word($sformatf("zw_c%0d_saddr", c), 64'(o_saddr), 64'(32'h20 + c - 1));
      check_bit($sformatf("zw_c%0d_mack", c), o_mack, exp_mack);
      if (exp_mack)
        check_word($sformatf("zw_c%0d_mdata", c), 64'(o_mdata), 64'((32'h20 + c - 2) ^ 32'h5A5A0000));
    end
    tie_ack = 1'b0;

    // Error on the second classic cycle
    $display("[TB] error mid-burst");
    apply_stimulus(1, 1, 0, 30'h30, 32'h0, 0, 0, 32'h0);
    apply_stimulus(1, 1, 0, 30'h31, 32'h0, 0, 0, 32'h0);
    check_word("er_c1_saddr", 64'(o_saddr), 64'h30);
    apply_stimulus(1, 1, 0, 30'h32, 32'h0, 1, 0, 32'h11111111);
    check_bit("er_c2_stall", o_mstall, 1'b0);
    apply_stimulus(1, 0, 0, 30'h0, 32'h0, 0, 1, 32'h0);
    check_bit("er_c3_scyc", o_scyc, 1'b1);
    check_word("er_c3_saddr", 64'(o_saddr), 64'h31);
    check_bit("er_c3_mack", o_mack, 1'b1);
    check_word("er_c3_mdata", 64'(o_mdata), 64'h11111111);
    apply_stimulus(1, 0, 0, 30'h0, 32'h0, 0, 0, 32'h0);
    check_bit("er_c4_merr", o_merr, 1'b1);
    check_bit("er_c4_mack", o_mack, 1'b0);
    check_bit("er_c4_scyc", o_scyc, 1'b0);
    check_bit("er_c4_stall", o_mstall, 1'b1);
    apply_stimulus(0, 0, 0, 30'h0, 32'h0, 0, 0, 32'h0);
    check_bit("er_c5_merr", o_merr, 1'b0);
    check_bit("er_c5_scyc", o_scyc, 1'b0);
    check_bit("er_c5_stall", o_mstall, 1'b1);
    apply_stimulus(0, 0, 0, 30'h0, 32'h0, 0, 0, 32'h0);
    check_bit("er_c6_stall", o_mstall, 1'b0);
    check_bit("er_c6_scyc", o_scyc, 1'b0);

    // Master abort while busy, with an ack in the same cycle
    $display("[TB] abort");
    apply_stimulus(1, 1, 0, 30'h40, 32'h0, 0, 0, 32'h0);
    apply_stimulus(1, 1, 0, 30'h44, 32'h0, 0, 0, 32'h0);
    check_bit("ab_c1_scyc", o_scyc, 1'b1);
    check_word("ab_c1_saddr", 64'(o_saddr), 64'h40);
    apply_stimulus(0, 0, 0, 30'h0, 32'h0, 1, 0, 32'h99);
    apply_stimulus(1, 1, 0, 30'h48, 32'h0, 0, 0, 32'h0);
    check_bit("ab_c3_mack", o_mack, 1'b0);
    check_bit("ab_c3_merr", o_merr, 1'b0);
    check_bit("ab_c3_scyc", o_scyc, 1'b0);
    check_bit("ab_c3_stall", o_mstall, 1'b0);
    check_word("ab_c3_mdata_hold", 64'(o_mdata), 64'h11111111);
    apply_stimulus(1, 0, 0, 30'h0, 32'h0, 1, 0, 32'h12345678);
    check_bit("ab_c4_scyc", o_scyc, 1'b1);
    check_word("ab_c4_saddr", 64'(o_saddr), 64'h48);
    apply_stimulus(1, 0, 0, 30'h0, 32'h0, 0, 0, 32'h0);
    check_bit("ab_c5_mack", o_mack, 1'b1);
    check_word("ab_c5_mdata", 64'(o_mdata), 64'h12345678);
    check_bit("ab_c5_scyc", o_scyc, 1'b0);

    // Reset while busy with two entries queued; the pending ack is lost
    $display("[TB] reset mid-cycle");
    apply_stimulus(1, 1, 0, 30'h50, 32'h0, 0, 0, 32'h0);
    apply_stimulus(1, 1, 0, 30'h54, 32'h0, 0, 0, 32'h0);
    apply_stimulus(1, 1, 0, 30'h58, 32'h0, 0, 0, 32'h0);
    apply_stimulus(1, 0, 0, 30'h0, 32'h0, 1, 0, 32'hCAFE0000);
    i_reset = 1'b1;
    #1;
    check_bit("rm_c3_stall", o_mstall, 1'b1);
    check_bit("rm_c3_scyc", o_scyc, 1'b1);
    apply_stimulus(1, 0, 0, 30'h0, 32'h0, 0, 0, 32'h0);
    check_bit("rm_c4_scyc", o_scyc, 1'b0);
    check_bit("rm_c4_sstb", o_sstb, 1'b0);
    check_bit("rm_c4_mack", o_mack, 1'b0);
    check_bit("rm_c4_merr", o_merr, 1'b0);
    check_word("rm_c4_mdata", 64'(o_mdata), 64'h0);
    check_word("rm_c4_saddr", 64'(o_saddr), 64'h0);
    check_word("rm_c4_sdata", 64'(o_sdata), 64'h0);
    check_word("rm_c4_ssel", 64'(o_ssel), 64'h0);
    check_bit("rm_c4_swe", o_swe, 1'b0);
    check_bit("rm_c4_stall", o_mstall, 1'b1);
    i_reset = 1'b0;
    apply_stimulus(1, 0, 0, 30'h0, 32'h0, 0, 0, 32'h0);
    check_bit("rm_c5_stall", o_mstall, 1'b0);
    check_bit("rm_c5_scyc", o_scyc, 1'b0);
    check_bit("rm_c5_mack", o_mack, 1'b0);
    apply_stimulus(1, 0, 0, 30'h0, 32'h0, 0, 0, 32'h0);
    check_bit("rm_c6_scyc", o_scyc, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
